// File: rtl/elelock_pkg.sv
// Shared definitions for the electronic lock and its keypad front ends.
// Provides the guard FSM state encoding, the key-pad width, the code length
// and a one-hot check used to validate raw key vectors.
package elelock_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned KEY_W      = 10;

  // Guard FSM state encoding.
  typedef logic [2:0] state_t;
  localparam state_t ST_OPEN     = 3'd0;
  localparam state_t ST_ENTRY    = 3'd1;
  localparam state_t ST_WAIT_REL = 3'd2;
  localparam state_t ST_CHECK    = 3'd3;
  localparam state_t ST_LOCKOUT  = 3'd4;

  // True when exactly one bit of v is set; v & (v - 1) clears the lowest set bit.
  function automatic logic is_one_hot(input logic [KEY_W-1:0] v);
    logic [KEY_W-1:0] one;
    one = {{(KEY_W-1){1'b0}}, 1'b1};
    return (v != '0) && ((v & (v - one)) == '0);
  endfunction

endpackage

// File: rtl/tenkey_edge.sv
// Ten-key press detector.
// Holds the previous raw key vector and flags a press event when the current
// vector is a single valid key and the previous cycle was fully released.
// Ports:
//   ck    - clock
//   reset - synchronous active-high reset
//   key   - raw key vector, bit n = digit n pressed
//   valid - current vector has exactly one bit set
//   press - valid key this cycle after an all-released cycle
module tenkey_edge
  import elelock_pkg::*;
(
  input  logic             ck,
  input  logic             reset,
  input  logic [KEY_W-1:0] key,
  output logic             valid,
  output logic             press
);

  logic [KEY_W-1:0] prev_q;

  // prev follows the raw pad every cycle, so a key held through any
  // blanking period never looks like a fresh press.
  always_ff @(posedge ck) begin
    if (reset) begin
      prev_q <= '0;
    end else begin
      prev_q <= key;
    end
  end

  always_comb begin
    valid = is_one_hot(key);
    press = valid && (prev_q == '0);
  end

endmodule

// File: rtl/elelock_guard.sv
// Attempt-limiting front end for the electronic lock.
// Gates and validates key presses, counts digits of each four-digit attempt,
// checks whether the lock opened after the attempt, and blanks the keypad
// with an alarm after MAX_FAIL consecutive failures.
// Ports:
//   ck         - clock
//   reset      - synchronous active-high reset
//   tenkey_in  - raw key pad vector
//   lock       - lock state from the lock block (1 = locked)
//   tenkey_out - gated key vector to the lock block
//   alarm      - high for the whole lockout period
//   fail_cnt   - consecutive failed attempts
//   digit_cnt  - digits accepted in the current attempt
module elelock_guard
  import elelock_pkg::*;
#(
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned LOCKOUT_CYCLES = 16,
  parameter int unsigned CHECK_DELAY    = 2
) (
  input  logic             ck,
  input  logic             reset,
  input  logic [KEY_W-1:0] tenkey_in,
  input  logic             lock,
  output logic [KEY_W-1:0] tenkey_out,
  output logic             alarm,
  output logic [2:0]       fail_cnt,
  output logic [2:0]       digit_cnt
);

  localparam int unsigned DlyW = $clog2(CHECK_DELAY + 1);
  localparam int unsigned LoW  = $clog2(LOCKOUT_CYCLES + 1);

  logic key_valid;
  logic key_press;

  state_t         state_q, state_d;
  logic [2:0]     fail_q, fail_d;
  logic [2:0]     digit_q, digit_d;
  logic           alarm_q, alarm_d;
  logic [DlyW-1:0] dly_q, dly_d;
  logic [LoW-1:0]  lo_q, lo_d;
  logic [2:0]     fail_next;

  tenkey_edge u_edge (
    .ck    (ck),
    .reset (reset),
    .key   (tenkey_in),
    .valid (key_valid),
    .press (key_press)
  );

  // Saturating increment so the count never wraps past MAX_FAIL.
  assign fail_next = (fail_q >= 3'(MAX_FAIL)) ? fail_q : fail_q + 3'd1;

  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    digit_d = digit_q;
    alarm_d = alarm_q;
    dly_d   = dly_q;
    lo_d    = lo_q;
    case (state_q)
      ST_OPEN: begin
        digit_d = '0;
        if (lock) state_d = ST_ENTRY;
      end
      ST_ENTRY: begin
        if (!lock) begin
          state_d = ST_OPEN;
          digit_d = '0;
          fail_d  = '0;
        end else if (key_press) begin
          digit_d = digit_q + 3'd1;
          if (digit_q == 3'(NUM_DIGITS - 1)) state_d = ST_WAIT_REL;
        end
      end
      ST_WAIT_REL: begin
        if (tenkey_in == '0) begin
          dly_d   = DlyW'(CHECK_DELAY);
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // The cycle that takes the delay to zero is the sampling cycle.
        if (dly_q <= DlyW'(1)) begin
          dly_d = '0;
          if (!lock) begin
            state_d = ST_OPEN;
            fail_d  = '0;
            digit_d = '0;
          end else begin
            fail_d  = fail_next;
            digit_d = '0;
            if (fail_next == 3'(MAX_FAIL)) begin
              state_d = ST_LOCKOUT;
              lo_d    = LoW'(LOCKOUT_CYCLES);
              alarm_d = 1'b1;
            end else begin
              state_d = ST_ENTRY;
            end
          end
        end else begin
          dly_d = dly_q - DlyW'(1);
        end
      end
      ST_LOCKOUT: begin
        if (lo_q <= LoW'(1)) begin
          lo_d    = '0;
          fail_d  = '0;
          alarm_d = 1'b0;
          state_d = ST_ENTRY;
        end else begin
          lo_d = lo_q - LoW'(1);
        end
      end
      default: begin
        state_d = lock ? ST_ENTRY : ST_OPEN;
      end
    endcase
  end

  always_ff @(posedge ck) begin
    if (reset) begin
      state_q <= lock ? ST_ENTRY : ST_OPEN;
      fail_q  <= '0;
      digit_q <= '0;
      alarm_q <= 1'b0;
      dly_q   <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
      digit_q <= digit_d;
      alarm_q <= alarm_d;
      dly_q   <= dly_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    tenkey_out = (key_valid && (state_q != ST_LOCKOUT)) ? tenkey_in : '0;
    alarm      = alarm_q;
    fail_cnt   = fail_q;
    digit_cnt  = digit_q;
  end

endmodule
